// File: rtl/mem_arbiter.sv
// Two-master memory arbiter and address decoder.
// Port A (debug) has fixed priority over port B (CPU). A starvation counter
// forces a B grant after STARVE consecutive A grants while B is waiting.
// The block also owns the control register whose bit 0 drives the CPU reset.
//
// Handshake: a port holds req/we/addr/wdata stable while req is high until it
// sees gnt. gnt is combinational, and the access is performed at the clock edge
// that ends the granted cycle. A granted read returns rvalid for exactly one
// cycle, in the cycle after the grant. rdata is meaningful only while rvalid is
// high, and it is driven to 0 otherwise.
module mem_arbiter #(
   parameter int STARVE = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic        a_we,
   input  logic [15:0] a_addr,
   input  logic [15:0] a_wdata,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [15:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [15:0] b_addr,
   input  logic [15:0] b_wdata,
   output logic        b_gnt,
   output logic        b_rvalid,
   output logic [15:0] b_rdata,
   output logic [15:0] m_addr,
   output logic [15:0] m_wdata,
   output logic [1:0]  sram_re,
   output logic [1:0]  sram_we,
   input  logic [15:0] sram_rdata0,
   input  logic [15:0] sram_rdata1,
   output logic        vram_we,
   output logic        cpu_reset_o
);

   // Target encoding of a decoded address.
   localparam logic [1:0] T_SRAM = 2'd0;
   localparam logic [1:0] T_VRAM = 2'd1;
   localparam logic [1:0] T_CTRL = 2'd2;
   localparam logic [1:0] T_NONE = 2'd3;

   localparam logic [3:0] STARVE_L = 4'(STARVE);

   logic [3:0]  starve_cnt;
   logic        rd_pend;
   logic        rd_port;     // 0 = port A, 1 = port B
   logic [1:0]  rd_tgt;
   logic        rd_bank;
   logic        ctrl_reg;

   logic        any_gnt;
   logic        m_we;
   logic [1:0]  m_tgt;
   logic [15:0] rd_data;

   // Grants: B wins when A is idle or A has used up its starvation budget.
   always_comb begin
      b_gnt = 1'b0;
      a_gnt = 1'b0;
      if (!reset) begin
         b_gnt = b_req && (!a_req || (starve_cnt == STARVE_L));
         a_gnt = a_req && !b_gnt;
      end
   end

   // Master mux and address decode; idle cycles show port A on the bus.
   always_comb begin
      any_gnt = a_gnt || b_gnt;
      m_addr  = b_gnt ? b_addr  : a_addr;
      m_wdata = b_gnt ? b_wdata : a_wdata;
      m_we    = b_gnt ? b_we    : a_we;
      case (m_addr[15:12])
         4'h0:    m_tgt = T_SRAM;
         4'h8:    m_tgt = T_VRAM;
         4'hF:    m_tgt = T_CTRL;
         default: m_tgt = T_NONE;
      endcase
   end

   // Per-target strobes for the granted access.
   always_comb begin
      sram_re = 2'b00;
      sram_we = 2'b00;
      vram_we = 1'b0;
      if (any_gnt) begin
         if (m_tgt == T_SRAM) begin
            if (m_we) sram_we[m_addr[8]] = 1'b1;
            else      sram_re[m_addr[8]] = 1'b1;
         end
         if (m_tgt == T_VRAM && m_we) vram_we = 1'b1;
      end
   end

   // Starvation counter: counts A grants that B had to watch, saturating.
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_cnt <= 4'd0;
      end else if (b_gnt || !b_req) begin
         starve_cnt <= 4'd0;
      end else if (a_gnt && starve_cnt != STARVE_L) begin
         starve_cnt <= starve_cnt + 4'd1;
      end
   end

   // Control register; bit 0 drives the CPU reset line.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_reg <= 1'b0;
      end else if (any_gnt && m_we && m_tgt == T_CTRL) begin
         ctrl_reg <= m_wdata[0];
      end
   end

   // Remember who owns the read returning next cycle and where it came from.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pend <= 1'b0;
         rd_port <= 1'b0;
         rd_tgt  <= T_NONE;
         rd_bank <= 1'b0;
      end else begin
         rd_pend <= any_gnt && !m_we;
         rd_port <= b_gnt;
         rd_tgt  <= m_tgt;
         rd_bank <= m_addr[8];
      end
   end

   // Return data selected by the registered read state, never the live grant.
   always_comb begin
      case (rd_tgt)
         T_SRAM:  rd_data = rd_bank ? sram_rdata1 : sram_rdata0;
         T_CTRL:  rd_data = {15'b0, ctrl_reg};
         default: rd_data = 16'h0000;
      endcase
      a_rvalid = rd_pend && !rd_port && !reset;
      b_rvalid = rd_pend &&  rd_port && !reset;
      a_rdata  = a_rvalid ? rd_data : 16'h0000;
      b_rdata  = b_rvalid ? rd_data : 16'h0000;
   end

   assign cpu_reset_o = ctrl_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios followed by randomized
// traffic, checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

   localparam int STARVE = 4;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        a_req, a_we, b_req, b_we;
   logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
   logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [15:0] a_rdata, b_rdata, m_addr, m_wdata;
   logic [1:0]  sram_re, sram_we;
   logic [15:0] sram_rdata0, sram_rdata1;
   logic        vram_we, cpu_reset_o;

   mem_arbiter #(.STARVE(STARVE)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .m_addr(m_addr), .m_wdata(m_wdata),
      .sram_re(sram_re), .sram_we(sram_we),
      .sram_rdata0(sram_rdata0), .sram_rdata1(sram_rdata1),
      .vram_we(vram_we), .cpu_reset_o(cpu_reset_o)
   );

   // ---------------- SRAM bank models (1-cycle read latency) ----------------
   logic [15:0] bank0 [256];
   logic [15:0] bank1 [256];
   logic        mem_ready = 1'b0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < 256; i++) begin
            bank0[i] <= 16'(i * 3 + 7);
            bank1[i] <= 16'(i * 5 + 1);
         end
         mem_ready <= 1'b1;
      end else begin
         if (sram_we[0]) bank0[m_addr[7:0]] <= m_wdata;
         if (sram_we[1]) bank1[m_addr[7:0]] <= m_wdata;
      end
      if (sram_re[0]) sram_rdata0 <= bank0[m_addr[7:0]];
      if (sram_re[1]) sram_rdata1 <= bank1[m_addr[7:0]];
   end

   // ---------------- reference model state ----------------
   logic [15:0] m_mem [512];      // {bank, index} -> word
   bit          m_ctrl;
   int          m_streak;         // A grants in a row while B has been waiting
   logic [15:0] exp_q [$];        // expected read data, one entry per read in flight
   bit          port_q [$];       // owner of each entry: 0 = A, 1 = B
   bit          last_ea, last_eb;
   int          a_cnt, b_cnt;
   int          checks = 0;
   int          failures = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_a(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
      a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
   endtask

   task automatic drive_b(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
      b_req = req; b_we = we; b_addr = addr; b_wdata = wd;
   endtask

   // One bus cycle: check all outputs against the model, advance the model
   // over the clock edge, then move to just after the edge.
   task automatic step();
      bit          ea, eb, we, busy, own, ev;
      logic [15:0] ad, wd, d;
      logic [3:0]  region;
      logic [1:0]  ere, ewe;
      bit          evw;
      #3;
      eb = !reset && b_req && (!a_req || m_streak >= STARVE);
      ea = !reset && a_req && !eb;
      busy = ea || eb;
      ad = eb ? b_addr : a_addr;
      wd = eb ? b_wdata : a_wdata;
      we = eb ? b_we : a_we;
      region = ad[15:12];
      ere = 2'b00; ewe = 2'b00; evw = 1'b0;
      if (busy && region == 4'h0) begin
         if (we) ewe[ad[8]] = 1'b1;
         else    ere[ad[8]] = 1'b1;
      end
      if (busy && we && region == 4'h8) evw = 1'b1;

      chk("a_gnt", 16'(a_gnt), 16'(ea));
      chk("b_gnt", 16'(b_gnt), 16'(eb));
      chk("one_gnt", 16'(a_gnt & b_gnt), 16'h0);
      chk("m_addr", m_addr, ad);
      chk("m_wdata", m_wdata, wd);
      chk("sram_we", 16'(sram_we), 16'(ewe));
      chk("sram_re", 16'(sram_re), 16'(ere));
      chk("vram_we", 16'(vram_we), 16'(evw));
      chk("cpu_reset_o", 16'(cpu_reset_o), 16'(m_ctrl));

      if (exp_q.size() > 0) begin
         d = exp_q.pop_front();
         own = port_q.pop_front();
         ev = !reset;
         chk("a_rvalid", 16'(a_rvalid), 16'(ev && !own));
         chk("b_rvalid", 16'(b_rvalid), 16'(ev && own));
         if (ev && !own) chk("a_rdata", a_rdata, d);
         if (ev && own)  chk("b_rdata", b_rdata, d);
      end else begin
         chk("a_rvalid", 16'(a_rvalid), 16'h0);
         chk("b_rvalid", 16'(b_rvalid), 16'h0);
      end

      // Model effect of the edge.
      if (reset) begin
         m_ctrl = 1'b0;
         m_streak = 0;
      end else begin
         if (busy && we) begin
            if (region == 4'h0) m_mem[{ad[8], ad[7:0]}] = wd;
            if (region == 4'hF) m_ctrl = wd[0];
         end
         if (busy && !we) begin
            if (region == 4'h0)      exp_q.push_back(m_mem[{ad[8], ad[7:0]}]);
            else if (region == 4'hF) exp_q.push_back({15'b0, m_ctrl});
            else                     exp_q.push_back(16'h0000);
            port_q.push_back(eb);
         end
         if (eb || !b_req) m_streak = 0;
         else if (ea && m_streak < STARVE) m_streak++;
      end
      if (ea) a_cnt++;
      if (eb) b_cnt++;
      last_ea = ea;
      last_eb = eb;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] rand_addr();
      logic [11:0] lo;
      lo = 12'($urandom());
      case ($urandom_range(0, 5))
         0, 1, 2: return {4'h0, lo};
         3:       return {4'h8, lo};
         4:       return {4'hF, lo};
         default: return {4'(3 + $urandom_range(0, 3)), lo};
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 256; i++) begin
         m_mem[i]       = 16'(i * 3 + 7);
         m_mem[256 + i] = 16'(i * 5 + 1);
      end
      m_ctrl = 1'b0; m_streak = 0; a_cnt = 0; b_cnt = 0;
      reset = 1'b1;
      drive_a(0, 0, 16'h0000, 16'h0000);
      drive_b(0, 0, 16'h0000, 16'h0000);
      @(posedge clk); @(posedge clk); #1;

      // Reset state, with requests present: nothing may be granted.
      drive_a(1, 1, 16'h0005, 16'h1111);
      drive_b(1, 1, 16'h0006, 16'h2222);
      step();
      reset = 1'b0;
      drive_a(0, 0, 16'h0000, 16'h0000);
      drive_b(0, 0, 16'h0000, 16'h0000);
      step();

      // Solo SRAM write/read on port B.
      drive_b(1, 1, 16'h0105, 16'h1234);
      step();
      drive_b(1, 0, 16'h0105, 16'h0000);
      step();
      drive_b(0, 0, 16'h0000, 16'h0000);
      #3;
      chk("solo_b_rvalid", 16'(b_rvalid), 16'h1);
      chk("solo_b_rdata", b_rdata, 16'h1234);
      chk("solo_a_rvalid", 16'(a_rvalid), 16'h0);
      #(-0);
      @(posedge clk); #1;
      void'(exp_q.pop_front());
      void'(port_q.pop_front());

      // Contention: both request for 20 cycles.
      a_cnt = 0; b_cnt = 0;
      drive_a(1, 0, 16'h0020, 16'h0000);
      drive_b(1, 0, 16'h0121, 16'h0000);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("pattern", 16'(last_eb), 16'((i % (STARVE + 1)) == STARVE));
      end
      chk("cont_a_cnt", 16'(a_cnt), 16'(20 * STARVE / (STARVE + 1)));
      chk("cont_b_cnt", 16'(b_cnt), 16'(20 / (STARVE + 1)));
      drive_a(0, 0, 16'h0000, 16'h0000);
      drive_b(0, 0, 16'h0000, 16'h0000);
      step();

      // CTRL register: set via A, read via B, clear via A.
      drive_a(1, 1, 16'hF000, 16'h0001);
      step();
      chk("ctrl_set", 16'(cpu_reset_o), 16'h1);
      drive_a(0, 0, 16'h0000, 16'h0000);
      drive_b(1, 0, 16'hF000, 16'h0000);
      step();
      drive_b(0, 0, 16'h0000, 16'h0000);
      drive_a(1, 1, 16'hF000, 16'h0000);
      step();
      drive_a(0, 0, 16'h0000, 16'h0000);
      step();
      chk("ctrl_clr", 16'(cpu_reset_o), 16'h0);

      // VRAM write, VRAM read, unmapped write.
      drive_b(1, 1, 16'h8123, 16'h00AB);
      step();
      drive_b(0, 0, 16'h0000, 16'h0000);
      drive_a(1, 0, 16'h8123, 16'h0000);
      step();
      drive_a(1, 1, 16'h4000, 16'h5A5A);
      step();
      drive_a(0, 0, 16'h0000, 16'h0000);
      step();

      // Pipelined reads to different banks on different ports.
      drive_b(1, 1, 16'h0010, 16'hAAAA);
      step();
      drive_b(1, 1, 16'h0110, 16'h5555);
      step();
      drive_b(0, 0, 16'h0000, 16'h0000);
      drive_a(1, 0, 16'h0010, 16'h0000);
      step();
      drive_a(0, 0, 16'h0000, 16'h0000);
      drive_b(1, 0, 16'h0110, 16'h0000);
      step();
      drive_b(0, 0, 16'h0000, 16'h0000);
      step();

      // Reset mid-read with CTRL set and the starve counter non-zero.
      drive_a(1, 1, 16'hF000, 16'h0001);
      step();
      drive_a(1, 0, 16'h0010, 16'h0000);
      drive_b(1, 0, 16'h0110, 16'h0000);
      step();
      reset = 1'b1;
      step();
      step();
      chk("rst_starve_cnt", 16'(dut.starve_cnt), 16'h0);
      chk("rst_ctrl", 16'(cpu_reset_o), 16'h0);
      reset = 1'b0;
      drive_a(0, 0, 16'h0000, 16'h0000);
      drive_b(0, 0, 16'h0000, 16'h0000);
      step();

      // Randomized traffic; a request is held unchanged until granted.
      for (int i = 0; i < 400; i++) begin
         if (!a_req || last_ea)
            drive_a(1'($urandom_range(0, 2) != 0), 1'($urandom()), rand_addr(), 16'($urandom()));
         if (!b_req || last_eb)
            drive_b(1'($urandom_range(0, 3) != 0), 1'($urandom()), rand_addr(), 16'($urandom()));
         reset = ($urandom_range(0, 79) == 0);
         step();
      end
      reset = 1'b0;
      drive_a(0, 0, 16'h0000, 16'h0000);
      drive_b(0, 0, 16'h0000, 16'h0000);
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
